// File: rtl/fetch_mem_arbiter_pkg.sv
// fetch_mem_arbiter_pkg
// Shared constants for the fetch/MEM memory arbiter: FSM state codes,
// owner encoding, default bus widths and the wait-counter width helper.
package fetch_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // FSM state codes
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_ACC  = 2'd1;
  localparam logic [1:0] S_MEM_ACC = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Owner of the access in flight
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Counter must hold 0..WAIT_CYCLES-1 with headroom to WAIT_CYCLES.
  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// fetch_mem_arbiter_if
// Bundles the IF-stage, MEM-stage and memory-side signals of the arbiter.
//   slave  : arbiter view (requests/ram_rdata in, ready/data/freeze/ram_* out)
//   master : pipeline + memory model view (the opposite directions)
interface fetch_mem_arbiter_if
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // IF stage
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  // MEM stage
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // Stall outputs
  logic              if_freeze;
  logic              pipe_freeze;
  // Memory side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, if_freeze, pipe_freeze,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, if_freeze, pipe_freeze,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/fetch_mem_arbiter_wait_counter.sv
// wait_counter
// Counts the cycles of one memory access. load clears, en advances,
// tc flags the last access cycle (count == WAIT_CYCLES-1) and the count
// wraps to 0 there.
//   clk, rst : clock, synchronous active-high reset
//   load     : clear count to 0
//   en       : advance count
//   tc       : terminal count
module wait_counter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int               CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else if (en)     cnt <= tc ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
// Shares one single-port memory between the IF fetch and the MEM load/store.
// Each access holds ram_en for WAIT_CYCLES cycles from registers latched at
// grant, captures ram_rdata on the last cycle, then spends one DONE cycle
// pulsing the owner's ready before returning to IDLE for re-arbitration.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_mem_arbiter_if.slave (IF/MEM handshakes, freezes, ram_*)
// Build option ARB_ROUND_ROBIN_EN: on a tie the requester that did not own
// the previous access wins; otherwise MEM always beats IF.
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  fetch_mem_arbiter_if.slave  bus
);

  logic [1:0]        state, state_nxt;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              in_acc, cnt_tc, last_beat;
  logic              grant_mem, grant_if;

  assign in_acc    = (state == S_IF_ACC) || (state == S_MEM_ACC);
  assign last_beat = in_acc && cnt_tc;

  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_IDLE),
    .en   (in_acc),
    .tc   (cnt_tc)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // Only a tie consults history: the side that did not go last wins.
  assign grant_mem = bus.mem_req && (!bus.if_req || (last_owner == OWN_IF));

  always_ff @(posedge clk) begin
    if (rst)            last_owner <= OWN_IF;
    else if (last_beat) last_owner <= owner;
  end
`else
  assign grant_mem = bus.mem_req;
`endif
  assign grant_if = bus.if_req && !grant_mem;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_mem)     state_nxt = S_MEM_ACC;
        else if (grant_if) state_nxt = S_IF_ACC;
      end
      S_IF_ACC,
      S_MEM_ACC: if (cnt_tc) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      // Latch the winner's request so requester changes mid-access are ignored.
      if (state == S_IDLE) begin
        if (grant_mem) begin
          owner   <= OWN_MEM;
          we_q    <= bus.mem_we;
          addr_q  <= bus.mem_addr;
          wdata_q <= bus.mem_wdata;
        end else if (grant_if) begin
          owner   <= OWN_IF;
          we_q    <= 1'b0;
          addr_q  <= bus.if_addr;
          wdata_q <= '0;
        end
      end
      if (last_beat) begin
        if (owner == OWN_IF) if_rdata_q  <= bus.ram_rdata;
        else if (!we_q)      mem_rdata_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_en      = in_acc;
  assign bus.ram_we      = (state == S_MEM_ACC) && we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.if_ready    = (state == S_DONE) && (owner == OWN_IF);
  assign bus.mem_ready   = (state == S_DONE) && (owner == OWN_MEM);
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.if_freeze   = bus.if_req  && !bus.if_ready;
  assign bus.pipe_freeze = bus.mem_req && !bus.mem_ready;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
module tb_fetch_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int W3 = 3;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  fetch_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();
  fetch_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));
  fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10)  return 32'hE3A01005;
    if (a == 32'h404) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  always_comb bus3.ram_rdata = memf(bus3.ram_addr);
  always_comb bus1.ram_rdata = memf(bus1.ram_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus3.if_req = 0; bus3.if_addr = 0; bus3.mem_req = 0; bus3.mem_we = 0;
    bus3.mem_addr = 0; bus3.mem_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.mem_req = 0; bus1.mem_we = 0;
    bus1.mem_addr = 0; bus1.mem_wdata = 0;
  endtask

  function automatic logic [31:0] raddr();
    if ($urandom_range(0, 9) == 0) return 32'h10;
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  typedef struct {
    logic ifr; logic [31:0] ifa;
    logic mr; logic mw; logic [31:0] ma; logic [31:0] md;
    logic en; logic we; logic [31:0] ra; logic [31:0] wd;
    logic ir; logic mrdy; logic ifz; logic pfz;
    logic [31:0] ird; logic [31:0] mrd;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  // Random traffic against a transaction-level model: each access is a
  // timeline counted from its grant edge (WAIT_CYCLES strobe cycles, one
  // ready cycle, one idle cycle).
  task automatic run_random(input int ncyc);
    int          gt = -1;
    logic        g_mem = 0, g_we = 0, last_mem = 0, tie_mem;
    logic [31:0] g_addr = 0, g_wd = 0, m_ird = 0, m_mrd = 0;
    logic        e_ir = 0, e_mr = 0, e_en, e_we;
    for (int c = 0; c < ncyc; c++) begin
      if (bus3.if_req && e_ir) begin
        bus3.if_req = 1'($urandom_range(0, 1)); bus3.if_addr = raddr();
      end else if (!bus3.if_req) begin
        bus3.if_req = ($urandom_range(0, 2) == 0); bus3.if_addr = raddr();
      end else begin
        if ($urandom_range(0, 7) == 0)  bus3.if_addr = raddr();
        if ($urandom_range(0, 15) == 0) bus3.if_req = 0;
      end
      if (bus3.mem_req && e_mr) begin
        bus3.mem_req = 1'($urandom_range(0, 1)); bus3.mem_addr = raddr();
        bus3.mem_we = 1'($urandom_range(0, 1)); bus3.mem_wdata = $urandom;
      end else if (!bus3.mem_req) begin
        bus3.mem_req = ($urandom_range(0, 2) == 0); bus3.mem_addr = raddr();
        bus3.mem_we = 1'($urandom_range(0, 1)); bus3.mem_wdata = $urandom;
      end else begin
        if ($urandom_range(0, 7) == 0)  bus3.mem_wdata = $urandom;
        if ($urandom_range(0, 15) == 0) bus3.mem_req = 0;
      end
      // model: what the coming clock edge does
      if (gt >= 0) begin
        if (gt == W3 - 1) begin
          if (!g_mem)     m_ird = memf(g_addr);
          else if (!g_we) m_mrd = memf(g_addr);
          last_mem = g_mem;
        end
        gt = gt + 1;
        if (gt > W3) gt = -1;
      end else if (bus3.mem_req || bus3.if_req) begin
        tie_mem = RR ? !last_mem : 1'b1;
        g_mem = bus3.mem_req && (!bus3.if_req || tie_mem);
        if (g_mem) begin
          g_addr = bus3.mem_addr; g_we = bus3.mem_we; g_wd = bus3.mem_wdata;
        end else begin
          g_addr = bus3.if_addr; g_we = 0; g_wd = 0;
        end
        gt = 0;
      end
      @(negedge clk);
      e_en = (gt >= 0) && (gt < W3);
      e_we = e_en && g_mem && g_we;
      e_ir = (gt == W3) && !g_mem;
      e_mr = (gt == W3) && g_mem;
      chk("rnd_ram_en", bus3.ram_en, e_en);
      chk("rnd_ram_we", bus3.ram_we, e_we);
      if (e_en) chk("rnd_ram_addr", bus3.ram_addr, g_addr);
      if (e_we) chk("rnd_ram_wdata", bus3.ram_wdata, g_wd);
      chk("rnd_if_ready", bus3.if_ready, e_ir);
      chk("rnd_mem_ready", bus3.mem_ready, e_mr);
      chk("rnd_if_rdata", bus3.if_rdata, m_ird);
      chk("rnd_mem_rdata", bus3.mem_rdata, m_mrd);
      chk("rnd_if_freeze", bus3.if_freeze, bus3.if_req && !e_ir);
      chk("rnd_pipe_freeze", bus3.pipe_freeze, bus3.mem_req && !e_mr);
    end
  endtask

  initial begin
    int          if_at, mem_at, k;
    int          rc [4];
    logic [31:0] ld, fa, st, dd, ee, ll;
    ld = 32'h404; fa = 32'h10; st = 32'h400; dd = 32'hDEADBEEF;
    ee = 32'hE3A01005; ll = 32'h12345678;

    for (int i = 0; i < 3; i++)  vec[i] = '{1, fa, 1, 0, ld, 0, 1, 0, ld, 0, 0, 0, 1, 1, 0, 0};
    vec[3] = '{1, fa, 1, 0, ld, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, ll};
    vec[4] = '{1, fa, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ll};
    for (int i = 5; i < 8; i++)  vec[i] = '{1, fa, 0, 0, 0, 0, 1, 0, fa, 0, 0, 0, 1, 0, 0, ll};
    vec[8] = '{1, fa, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ee, ll};
    vec[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ee, ll};
    for (int i = 10; i < 13; i++) vec[i] = '{0, 0, 1, 1, st, dd, 1, 1, st, dd, 0, 0, 0, 1, ee, ll};
    vec[13] = '{0, 0, 1, 1, st, dd, 0, 0, 0, 0, 0, 1, 0, 0, ee, ll};
    vec[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ee, ll};

    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_ram_en", bus3.ram_en, 0);
    chk("rst_ram_we", bus3.ram_we, 0);
    chk("rst_ram_addr", bus3.ram_addr, 0);
    chk("rst_ram_wdata", bus3.ram_wdata, 0);
    chk("rst_if_ready", bus3.if_ready, 0);
    chk("rst_mem_ready", bus3.mem_ready, 0);
    chk("rst_if_rdata", bus3.if_rdata, 0);
    chk("rst_mem_rdata", bus3.mem_rdata, 0);
    rst = 0;

    // Tie (MEM wins from reset), then IF-only fetch, then a store.
    for (int i = 0; i < NV; i++) begin
      bus3.if_req = vec[i].ifr;  bus3.if_addr = vec[i].ifa;
      bus3.mem_req = vec[i].mr;  bus3.mem_we = vec[i].mw;
      bus3.mem_addr = vec[i].ma; bus3.mem_wdata = vec[i].md;
      @(negedge clk);
      chk("vec_ram_en", bus3.ram_en, vec[i].en);
      chk("vec_ram_we", bus3.ram_we, vec[i].we);
      if (vec[i].en) chk("vec_ram_addr", bus3.ram_addr, vec[i].ra);
      if (vec[i].we) chk("vec_ram_wdata", bus3.ram_wdata, vec[i].wd);
      chk("vec_if_ready", bus3.if_ready, vec[i].ir);
      chk("vec_mem_ready", bus3.mem_ready, vec[i].mrdy);
      chk("vec_if_freeze", bus3.if_freeze, vec[i].ifz);
      chk("vec_pipe_freeze", bus3.pipe_freeze, vec[i].pfz);
      chk("vec_if_rdata", bus3.if_rdata, vec[i].ird);
      chk("vec_mem_rdata", bus3.mem_rdata, vec[i].mrd);
    end

    // Tie after a MEM-owned access: round robin hands it to IF.
    bus3.if_req = 1; bus3.if_addr = fa;
    bus3.mem_req = 1; bus3.mem_we = 0; bus3.mem_addr = ld;
    if_at = -1; mem_at = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("tie_first_addr", bus3.ram_addr, RR ? fa : ld);
      if (bus3.if_ready)  begin if_at = c;  bus3.if_req = 0;  end
      if (bus3.mem_ready) begin mem_at = c; bus3.mem_req = 0; end
    end
    chk("tie_if_ready_cycle", if_at, RR ? 3 : 8);
    chk("tie_mem_ready_cycle", mem_at, RR ? 8 : 3);

    // Reset during the second cycle of a fetch.
    bus3.if_req = 1; bus3.if_addr = 32'h20;
    @(negedge clk);
    chk("rmid_en_c0", bus3.ram_en, 1);
    chk("rmid_addr_c0", bus3.ram_addr, 32'h20);
    @(negedge clk);
    chk("rmid_en_c1", bus3.ram_en, 1);
    rst = 1;
    @(negedge clk);
    chk("rmid_en_after_rst", bus3.ram_en, 0);
    chk("rmid_ready_after_rst", bus3.if_ready, 0);
    chk("rmid_freeze_after_rst", bus3.if_freeze, 1);
    rst = 0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      chk("rmid_restart_en", bus3.ram_en, c < 6);
      chk("rmid_restart_ready", bus3.if_ready, c == 6);
    end
    chk("rmid_rdata", bus3.if_rdata, memf(32'h20));
    bus3.if_req = 0;
    @(negedge clk);

    // Request dropped and address changed right after grant.
    bus3.if_req = 1; bus3.if_addr = 32'h30;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("drop_en", bus3.ram_en, c < 3);
      if (c < 3) chk("drop_addr", bus3.ram_addr, 32'h30);
      chk("drop_ready", bus3.if_ready, c == 3);
      if (c == 0) begin bus3.if_req = 0; bus3.if_addr = 32'h99; end
    end
    chk("drop_rdata", bus3.if_rdata, memf(32'h30));

    // WAIT_CYCLES=1: back-to-back fetches 0,4,8,12.
    k = 0;
    bus1.if_req = 1; bus1.if_addr = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      if (bus1.if_ready) begin
        chk("w1_rdata", bus1.if_rdata, memf(32'(4 * k)));
        rc[k] = c;
        k++;
        bus1.if_addr = 32'(4 * k);
        if (k == 4) bus1.if_req = 0;
      end
    end
    chk("w1_fetch_count", k, 4);
    for (int j = 0; j < k; j++) chk("w1_ready_cycle", rc[j], 1 + 3 * j);

    // Randomized traffic from a fresh reset.
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
